alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Hardwired control unit directly upstream of DataPath.
- Steps fetch (T0-T2) and execute (T3-T6) for register-register ALU instructions, one control step per clock.
- Replaces the hand-sequenced control signals currently driven by the datapath benches.
- Register selection is emitted as Gra/Grb/Grc/Rin/Rout strobes for the select-and-encode logic feeding R0-R15 in/out.

Parameters:
MAX_WAIT, 15, cycles T1 may stall waiting for Mem_ready before the block halts with Mem_timeout.
CNT_W, 32, width of the optional retired-instruction counter.

Ports:
Clock  in  1  system clock, rising edge.
clear  in  1  asynchronous active-high reset.
IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
Mem_ready  in  1  memory data valid on Mdatain during T1.
Stop  in  1  request halt at next instruction boundary.
PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
Zin_low, Zin_high, Zlowout, Zhighout, LOin, HIin  out  1 each  Z/HI/LO strobes.
Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and direction.
operation  out  4  ALU function code.
Run  out  1  high while sequencing.
Illegal  out  1  sticky; unsupported opcode decoded.
Mem_timeout  out  1  sticky; MAX_WAIT exceeded.
instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset/clock: single clock Clock; clear is asynchronous, active-high.
- Reset response: clear forces state RST, all strobes 0, operation=0, Run=1, Illegal=0, Mem_timeout=0, instr_count=0, immediately and regardless of Clock. Mid-instruction clear aborts with no partial strobes.
- Output timing: strobes are registered. A strobe is high for exactly the cycle the FSM occupies the named state.
- States: RST, T0, T1, T1W, T2, T3, T4, T5, T6, HALT.
- RST -> T0: on first edge after clear falls.
- T0: PCout, MARin, IncPC, Zin_low.
- T1: Zlowout, PCin, Read, MDRin.
  - Mem_ready=1 -> T2.
  - Else -> T1W.
- T1W: Read, MDRin only; PCin is never repeated.
  - Mem_ready=1 -> T2.
  - After MAX_WAIT consecutive T1W cycles with no Mem_ready -> HALT, Mem_timeout=1.
- T2: MDRout, IRin. IR is sampled at the T2 -> T3 edge.
- Opcode map: operation = opcode[3:0] for opcodes 00000-01011: add, sub, and, or, shl, shr, ror, rol, mul, div, neg, not. Any other opcode -> HALT, Illegal=1, no T3 strobes.
- Binary class (add-rol):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, operation, Zin_low.
  - T5: Zlowout, Gra, Rin. Retire.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, operation, Zin_low, Zin_high.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Retire.
- Unary (neg/not):
  - T3: Grb, Rout, operation, Zin_low.
  - T4: Zlowout, Gra, Rin. Retire.
- Instruction length: binary 6 cycles, mul/div 7, unary 5, excluding T1W stalls.
- Retire: next state T0, unless a stop is pending, in which case HALT.
- Stop: a high level in any cycle sets stop_pending. Clearing Stop later does not cancel it. stop_pending is cleared only by clear.
- HALT: all strobes 0, Run=0. Exited only by clear.
- Priority: clear > Mem_timeout > Illegal > Stop.
- operation outside its T3/T4 assertion cycle holds its last value. Bench checks operation only when Zin_low=1.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined: instr_count increments by 1 (wrapping at 2^CNT_W) on each retire edge. Not incremented on HALT entry via Illegal or Mem_timeout.
- Undefined: counter logic omitted, instr_count tied to 0.

Test Plan:
- IR=0x10918000 (and R1,R2,R3), Mem_ready tied 1:
  - T3: Grb+Rout+Yin.
  - T4: Grc+Rout, operation=0010, Zin_low.
  - T5: Gra+Rin.
  - T0 again 6 cycles after first T0.
  - instr_count=1 if INSTR_COUNT_EN.
- IR=0x281A8000 (shr R0,R3,R5), Mem_ready low 3 cycles:
  - PCin exactly once, Read/MDRin high 4 cycles.
  - operation=0101 in T4.
  - Total 9 cycles.
- IR=0x42300000 (mul R4,R6):
  - T4: Zin_low and Zin_high together.
  - T5: LOin.
  - T6: HIin.
  - 7 cycles.
- IR=0xF8000000:
  - HALT after T2, Illegal=1, Run=0, no Gr*/Rout.
  - Remains halted 20 cycles until clear.
- Mem_ready held 0:
  - Mem_timeout=1 after 15 T1W cycles, HALT.
  - clear pulse restores RST with all outputs 0.
- Stop pulsed 1 cycle during T3 of add; clear asserted mid-T4 of a second run:
  - First run: instruction retires, then HALT with Run=0.
  - Second run: outputs drop to 0 asynchronously, before the next Clock edge.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: hardwired fetch/execute control for register-register ALU instructions.
// Optional retired-instruction counter enabled by INSTR_COUNT_EN.
module alu_instr_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             Mem_ready,
    input  logic             Stop,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin_low,
    output logic             Zin_high,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             LOin,
    output logic             HIin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [3:0]       operation,
    output logic             Run,
    output logic             Illegal,
    output logic             Mem_timeout,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
    typedef enum logic [3:0] {RST, T0, T1, T1W, T2, T3, T4, T5, T6, HALT} state_t;
    typedef enum logic [1:0] {BIN, MD, UN} cls_t;
    typedef struct packed {
        logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin_low;
        logic Zin_high, Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout;
    } ctl_t;
    state_t state, ns;
    cls_t cls, cls_d;
    ctl_t ctl, ctl_d;
    logic [3:0] opc, opc_d, op_d;
    logic [WW-1:0] wcnt, wcnt_d;
    logic stop_pending, retire, illegal_d, timeout_d;
    logic unused;
    assign unused = ^IR[26:0];
    assign {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin_low,
            Zin_high, Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout} = ctl;
    always_comb begin
        ns = state;
        cls_d = cls;
        opc_d = opc;
        wcnt_d = wcnt;
        retire = 1'b0;
        illegal_d = Illegal;
        timeout_d = Mem_timeout;
        case (state)
            RST: ns = T0;
            T0: ns = T1;
            T1: begin
                ns = Mem_ready ? T2 : T1W;
                wcnt_d = WW'(1);
            end
            T1W: begin
                if (Mem_ready) ns = T2;
                else if (wcnt == WMAX) begin
                    ns = HALT;
                    timeout_d = 1'b1;
                end else wcnt_d = wcnt + WW'(1);
            end
            T2: begin
                opc_d = IR[30:27];
                cls_d = IR[31:27] >= 5'd10 ? UN : IR[31:27] >= 5'd8 ? MD : BIN;
                ns = IR[31:27] > 5'd11 ? HALT : T3;
                illegal_d = IR[31:27] > 5'd11;
            end
            T3: ns = T4;
            T4: if (cls == UN) retire = 1'b1; else ns = T5;
            T5: if (cls == BIN) retire = 1'b1; else ns = T6;
            T6: retire = 1'b1;
            default: ;
        endcase
        // a Stop seen on the retire edge itself also counts as pending
        if (retire) ns = (stop_pending || Stop) ? HALT : T0;
    end
    always_comb begin
        ctl_d = '0;
        case (ns)
            T0: {ctl_d.PCout, ctl_d.MARin, ctl_d.IncPC, ctl_d.Zin_low} = 4'hF;
            T1: {ctl_d.Zlowout, ctl_d.PCin, ctl_d.Read, ctl_d.MDRin} = 4'hF;
            T1W: {ctl_d.Read, ctl_d.MDRin} = 2'b11;
            T2: {ctl_d.MDRout, ctl_d.IRin} = 2'b11;
            T3: begin
                if (cls_d == MD) {ctl_d.Gra, ctl_d.Rout, ctl_d.Yin} = 3'b111;
                else if (cls_d == UN) {ctl_d.Grb, ctl_d.Rout, ctl_d.Zin_low} = 3'b111;
                else {ctl_d.Grb, ctl_d.Rout, ctl_d.Yin} = 3'b111;
            end
            T4: begin
                if (cls_d == MD) {ctl_d.Grb, ctl_d.Rout, ctl_d.Zin_low, ctl_d.Zin_high} = 4'hF;
                else if (cls_d == UN) {ctl_d.Zlowout, ctl_d.Gra, ctl_d.Rin} = 3'b111;
                else {ctl_d.Grc, ctl_d.Rout, ctl_d.Zin_low} = 3'b111;
            end
            T5: begin
                if (cls_d == MD) {ctl_d.Zlowout, ctl_d.LOin} = 2'b11;
                else {ctl_d.Zlowout, ctl_d.Gra, ctl_d.Rin} = 3'b111;
            end
            T6: {ctl_d.Zhighout, ctl_d.HIin} = 2'b11;
            default: ;
        endcase
        op_d = ((ns == T3 && cls_d == UN) || (ns == T4 && cls_d != UN)) ? opc_d : operation;
    end
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state <= RST;
            cls <= BIN;
            opc <= '0;
            wcnt <= '0;
            ctl <= '0;
            operation <= '0;
            Run <= 1'b1;
            Illegal <= 1'b0;
            Mem_timeout <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            state <= ns;
            cls <= cls_d;
            opc <= opc_d;
            wcnt <= wcnt_d;
            ctl <= ctl_d;
            operation <= op_d;
            Run <= ns != HALT;
            Illegal <= illegal_d;
            Mem_timeout <= timeout_d;
            if (Stop) stop_pending <= 1'b1;
        end
    end
`ifdef INSTR_COUNT_EN
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end
`else
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: directed scenarios plus randomized traffic against a table-driven
// model of the instruction timing.
module tb_alu_instr_sequencer;
    localparam int MAX_WAIT = 15;
`ifdef INSTR_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif
    localparam logic [19:0] PCO = 20'd1 << 19, MAR = 20'd1 << 18, INC = 20'd1 << 17, PCI = 20'd1 << 16;
    localparam logic [19:0] RD = 20'd1 << 15, MDI = 20'd1 << 14, MDO = 20'd1 << 13, IRI = 20'd1 << 12;
    localparam logic [19:0] YI = 20'd1 << 11, ZL = 20'd1 << 10, ZH = 20'd1 << 9, ZLO = 20'd1 << 8;
    localparam logic [19:0] ZHO = 20'd1 << 7, LOI = 20'd1 << 6, HII = 20'd1 << 5, GRA = 20'd1 << 4;
    localparam logic [19:0] GRB = 20'd1 << 3, GRC = 20'd1 << 2, RI = 20'd1 << 1, RO = 20'd1;
    localparam int P_RST = 0, P_T0 = 1, P_T1 = 2, P_W = 3, P_T2 = 4, P_EX = 5, P_HALT = 6;

    logic Clock = 1'b0, clear = 1'b1, Mem_ready = 1'b1, Stop = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin_low;
    logic Zin_high, Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout;
    logic [3:0] operation;
    logic Run, Illegal, Mem_timeout;
    logic [31:0] instr_count;
    logic [19:0] strb;
    int vectors = 0, miscompares = 0;

    alu_instr_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin_low(Zin_low), .Zin_high(Zin_high),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .operation(operation), .Run(Run), .Illegal(Illegal),
        .Mem_timeout(Mem_timeout), .instr_count(instr_count)
    );
    assign strb = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin_low,
                   Zin_high, Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout};
    always #5 Clock = ~Clock;

    // Reference: per-class execute-step tables, fetch with a bounded memory wait
    function automatic logic [19:0] exec_strb(input int c, input int k);
        if (c == 1) return k == 0 ? GRA | RO | YI : k == 1 ? GRB | RO | ZL | ZH : k == 2 ? ZLO | LOI : ZHO | HII;
        if (c == 2) return k == 0 ? GRB | RO | ZL : ZLO | GRA | RI;
        return k == 0 ? GRB | RO | YI : k == 1 ? GRC | RO | ZL : ZLO | GRA | RI;
    endfunction
    function automatic int exec_len(input int c);
        return c == 1 ? 4 : c == 2 ? 2 : 3;
    endfunction

    int m_ph = P_RST, m_k = 0, m_w = 0, m_cls = 0;
    logic [3:0] m_op = '0;
    logic m_ill = 1'b0, m_tmo = 1'b0, m_stop = 1'b0;
    logic [31:0] m_cnt = '0;
    logic [19:0] m_strb;

    always @(posedge Clock or posedge clear) begin
        if (clear) begin
            m_ph <= P_RST; m_k <= 0; m_w <= 0; m_ill <= 1'b0; m_tmo <= 1'b0; m_stop <= 1'b0; m_cnt <= '0;
        end else begin
            if (Stop) m_stop <= 1'b1;
            case (m_ph)
                P_RST: m_ph <= P_T0;
                P_T0: m_ph <= P_T1;
                P_T1: begin m_w <= 0; m_ph <= Mem_ready ? P_T2 : P_W; end
                P_W: begin
                    if (Mem_ready) m_ph <= P_T2;
                    else if (m_w + 1 >= MAX_WAIT) begin m_ph <= P_HALT; m_tmo <= 1'b1; end
                    else m_w <= m_w + 1;
                end
                P_T2: begin
                    if (int'(IR[31:27]) > 11) begin m_ph <= P_HALT; m_ill <= 1'b1; end
                    else begin
                        m_ph <= P_EX; m_k <= 0; m_op <= IR[30:27];
                        m_cls <= int'(IR[31:27]) >= 10 ? 2 : int'(IR[31:27]) >= 8 ? 1 : 0;
                    end
                end
                P_EX: begin
                    if (m_k == exec_len(m_cls) - 1) begin
                        m_cnt <= m_cnt + 1;
                        m_ph <= (m_stop || Stop) ? P_HALT : P_T0;
                    end else m_k <= m_k + 1;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        m_strb = '0;
        case (m_ph)
            P_T0: m_strb = PCO | MAR | INC | ZL;
            P_T1: m_strb = ZLO | PCI | RD | MDI;
            P_W: m_strb = RD | MDI;
            P_T2: m_strb = MDO | IRI;
            P_EX: m_strb = exec_strb(m_cls, m_k);
            default: ;
        endcase
    end

    always @(negedge Clock) begin
        vectors++;
        if (strb !== m_strb || Run !== (m_ph != P_HALT) || Illegal !== m_ill || Mem_timeout !== m_tmo ||
            instr_count !== (CNT_ON != 0 ? m_cnt : 32'd0) ||
            (m_ph == P_EX && m_strb[10] && operation !== m_op)) begin
            miscompares++;
            $display("FAIL cycle t=%0t strobes %h want %h run %b want %b ill %b want %b tmo %b want %b cnt %0d want %0d op %h want %h",
                     $time, strb, m_strb, Run, m_ph != P_HALT, Illegal, m_ill, Mem_timeout, m_tmo,
                     instr_count, CNT_ON != 0 ? m_cnt : 32'd0, operation, m_op);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step;
        @(negedge Clock);
        #1;
    endtask
    task automatic wait_for(input string name, input int sel);
        for (int i = 0; i < 100; i++) begin
            step();
            if ((sel == 0 && PCout) || (sel == 1 && Yin) || (sel == 2 && Zin_low && Grc)) return;
        end
        chk({name, "_timeout"}, 1, 0);
    endtask

    logic [19:0] hist [0:31];
    // Caller is positioned in T0; returns positioned in the next T0.
    task automatic run_instr(input string name, input logic [31:0] ir, input int low,
                             input int exp_len, input logic [3:0] exp_op);
        int n = 0, pcin = 0, reads = 0;
        IR = ir;
        Mem_ready = 1'b1;
        hist[0] = strb;
        while (n < 30) begin
            step();
            n++;
            Mem_ready = !(n >= 1 && n <= low);
            if (PCout) break;
            hist[n] = strb;
            if (PCin) pcin++;
            if (Read) reads++;
            if (Zin_low) chk({name, "_op"}, 64'(operation), 64'(exp_op));
        end
        chk({name, "_len"}, 64'(n), 64'(exp_len));
        chk({name, "_pcin"}, 64'(pcin), 1);
        chk({name, "_reads"}, 64'(reads), 64'(low + 1));
    endtask

    initial begin
        int w, grs, ret, pc;
        logic [31:0] cnt0;
        logic [4:0] op5;
        int halted = 0, starve = 0;
        repeat (3) step();
        chk("rst_strb", 64'(strb), 0);
        chk("rst_run", 64'(Run), 1);
        chk("rst_flags", 64'({Illegal, Mem_timeout}), 0);
        chk("rst_cnt", 64'(instr_count), 0);
        chk("rst_op", 64'(operation), 0);
        clear = 1'b0;
        wait_for("first_t0", 0);
        run_instr("and", 32'h10918000, 0, 6, 4'b0010);
        chk("and_t3", 64'(hist[3]), 64'(GRB | RO | YI));
        chk("and_t4", 64'(hist[4]), 64'(GRC | RO | ZL));
        chk("and_t5", 64'(hist[5]), 64'(ZLO | GRA | RI));
        chk("and_cnt", 64'(instr_count), 64'(CNT_ON));
        run_instr("shr", 32'h281A8000, 3, 9, 4'b0101);
        run_instr("mul", 32'h42300000, 0, 7, 4'b1000);
        chk("mul_t4", 64'(hist[4]), 64'(GRB | RO | ZL | ZH));
        chk("mul_t5", 64'(hist[5]), 64'(ZLO | LOI));
        chk("mul_t6", 64'(hist[6]), 64'(ZHO | HII));
        // Illegal opcode: halts after T2 and stays halted
        IR = 32'hF8000000;
        grs = 0;
        for (int i = 1; i <= 23; i++) begin
            step();
            if (Gra || Grb || Grc || Rout) grs++;
            if (i == 3) chk("ill_halt_run", 64'(Run), 0);
        end
        chk("ill_flag", 64'(Illegal), 1);
        chk("ill_run", 64'(Run), 0);
        chk("ill_gr", 64'(grs), 0);
        // Memory timeout
        clear = 1'b1;
        step();
        chk("clr_flags", 64'({Run, Illegal, Mem_timeout}), 64'(3'b100));
        clear = 1'b0;
        Mem_ready = 1'b0;
        wait_for("tmo_t0", 0);
        w = 0;
        for (int i = 0; i < 40 && Run; i++) begin
            step();
            if (Read && !PCin) w++;
        end
        chk("tmo_waits", 64'(w), 64'(MAX_WAIT));
        chk("tmo_flag", 64'({Mem_timeout, Run}), 64'(2'b10));
        clear = 1'b1;
        #1;
        chk("tmo_clr", 64'({strb, operation, Run, Illegal, Mem_timeout}), 64'(3'b100));
        step();
        clear = 1'b0;
        Mem_ready = 1'b1;
        // Stop pulse during T3 of add: retire, then halt
        IR = 32'h00918000;
        wait_for("stop_t0", 0);
        cnt0 = instr_count;
        wait_for("stop_t3", 1);
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        ret = 0;
        pc = 0;
        for (int i = 0; i < 10 && Run; i++) begin
            if (Gra && Rin) ret++;
            if (PCout) pc++;
            step();
        end
        chk("stop_retired", 64'(ret), 1);
        chk("stop_no_t0", 64'(pc), 0);
        chk("stop_run", 64'(Run), 0);
        chk("stop_cnt", 64'(instr_count - cnt0), 64'(CNT_ON));
        // Asynchronous clear mid-T4
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_for("async_t0", 0);
        wait_for("async_t4", 2);
        clear = 1'b1;
        #1;
        chk("async_strb", 64'(strb), 0);
        chk("async_run", 64'({Run, instr_count}), 64'({1'b1, 32'd0}));
        step();
        clear = 1'b0;
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            if (starve == 0 && $urandom_range(0, 299) == 0) starve = 20;
            Mem_ready = starve > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (starve > 0) starve--;
            Stop = $urandom_range(0, 149) == 0;
            op5 = $urandom_range(0, 11) == 0 ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
            IR = {op5, 27'($urandom)};
            halted = (Run || clear) ? 0 : halted + 1;
            clear = (halted > 2) || ($urandom_range(0, 499) == 0);
        end
        clear = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
